// File: rtl/usb_serial_rx_buffer.sv
// usb_serial_rx_buffer
//   Receive-side byte buffer between the USB-serial core and a byte consumer.
//   Bytes strobed on recv_valid are written into a 2^ASIZE x 8 synchronous-read
//   memory and forwarded through a one-byte output register with a
//   valid/ready handshake. Bytes arriving while the memory is full are dropped
//   and counted.
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   recv_data/valid  : incoming byte and its one-cycle strobe (no backpressure)
//   out_data/valid   : byte presented to the consumer
//   out_ready        : consumer accepts out_data when out_valid is high
//   level            : bytes held (memory count plus output register)
//   line_avail       : at least one 0x0A byte is held
//   overflow         : sticky flag, set when a byte is dropped
//   drop_cnt         : saturating count of dropped bytes
//   clr_overflow     : one-cycle clear of overflow and drop_cnt
module usb_serial_rx_buffer #(
    parameter int unsigned ASIZE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       recv_data,
    input  logic             recv_valid,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ASIZE:0]   level,
    output logic             line_avail,
    output logic             overflow,
    output logic [15:0]      drop_cnt,
    input  logic             clr_overflow
);

    localparam int unsigned DEPTH = 1 << ASIZE;

    logic [7:0]     mem [DEPTH];

    logic [ASIZE:0] wptr_q, wptr_d;
    logic [ASIZE:0] rptr_q, rptr_d;
    logic [ASIZE:0] line_cnt_q, line_cnt_d;
    logic [7:0]     out_data_q;
    logic           out_valid_q, out_valid_d;
    logic           overflow_q, overflow_d;
    logic [15:0]    drop_cnt_q, drop_cnt_d;

    logic empty, full, wr_en, drop, consume, load, wr_nl, rd_nl;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q == {~rptr_q[ASIZE], rptr_q[ASIZE-1:0]});
    assign wr_en   = recv_valid && !full;
    assign drop    = recv_valid && full;
    assign consume = out_valid_q && out_ready;
    // Refill the output register whenever it is free or being emptied this cycle.
    assign load    = !empty && (!out_valid_q || out_ready);
    assign wr_nl   = wr_en && (recv_data == 8'h0A);
    assign rd_nl   = consume && (out_data_q == 8'h0A);

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        out_valid_d = out_valid_q;
        line_cnt_d  = line_cnt_q;
        overflow_d  = overflow_q;
        drop_cnt_d  = drop_cnt_q;

        if (wr_en) begin
            wptr_d = wptr_q + 1'b1;
        end

        if (load) begin
            rptr_d      = rptr_q + 1'b1;
            out_valid_d = 1'b1;
        end else if (consume) begin
            out_valid_d = 1'b0;
        end

        case ({wr_nl, rd_nl})
            2'b10:   line_cnt_d = line_cnt_q + 1'b1;
            2'b01:   line_cnt_d = line_cnt_q - 1'b1;
            default: line_cnt_d = line_cnt_q;
        endcase

        // A drop in the same cycle as a clear restarts the count at one.
        if (drop) begin
            overflow_d = 1'b1;
            if (clr_overflow) begin
                drop_cnt_d = 16'd1;
            end else if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            out_valid_q <= 1'b0;
            line_cnt_q  <= '0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            out_valid_q <= out_valid_d;
            line_cnt_q  <= line_cnt_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Memory array has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wptr_q[ASIZE-1:0]] <= recv_data;
        end
    end

    // Synchronous read port doubles as the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q <= '0;
        end else if (load) begin
            out_data_q <= mem[rptr_q[ASIZE-1:0]];
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign level      = (wptr_q - rptr_q) + {{ASIZE{1'b0}}, out_valid_q};
    assign line_avail = (line_cnt_q != '0);
    assign overflow   = overflow_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_usb_serial_rx_buffer.sv
// Testbench for usb_serial_rx_buffer: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the buffer contents.
module tb_usb_serial_rx_buffer;

    localparam int unsigned ASIZE = 8;
    localparam int unsigned DEPTH = 1 << ASIZE;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       recv_data = '0;
    logic             recv_valid = 1'b0;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [ASIZE:0]   level;
    logic             line_avail;
    logic             overflow;
    logic [15:0]      drop_cnt;
    logic             clr_overflow = 1'b0;

    int total = 0;
    int bad   = 0;

    // Model: bytes waiting in memory, plus the output register.
    logic [7:0] mq[$];
    logic       m_ov  = 1'b0;
    logic [7:0] m_od  = '0;
    logic       m_ovf = 1'b0;
    int         m_dc  = 0;

    usb_serial_rx_buffer #(.ASIZE(ASIZE)) dut (
        .clk          (clk),
        .rst          (rst),
        .recv_data    (recv_data),
        .recv_valid   (recv_valid),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .level        (level),
        .line_avail   (line_avail),
        .overflow     (overflow),
        .drop_cnt     (drop_cnt),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_has_nl();
        logic r;
        r = m_ov && (m_od == 8'h0A);
        foreach (mq[i]) if (mq[i] == 8'h0A) r = 1'b1;
        return r;
    endfunction

    // One clock cycle: drive inputs, advance the model at the edge, compare.
    task automatic step(input logic rv, input logic [7:0] rd, input logic rdy,
                        input logic clr, input logic r);
        logic acc, drp, cons, ld;
        @(negedge clk);
        recv_valid   = rv;
        recv_data    = rd;
        out_ready    = rdy;
        clr_overflow = clr;
        rst          = r;
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_ov  = 1'b0;
            m_od  = '0;
            m_ovf = 1'b0;
            m_dc  = 0;
        end else begin
            acc  = rv && (mq.size() < DEPTH);
            drp  = rv && !acc;
            cons = m_ov && rdy;
            ld   = (mq.size() > 0) && (!m_ov || rdy);
            if (ld) begin
                m_od = mq.pop_front();
                m_ov = 1'b1;
            end else if (cons) begin
                m_ov = 1'b0;
            end
            if (acc) mq.push_back(rd);
            if (drp) begin
                m_ovf = 1'b1;
                m_dc  = clr ? 1 : ((m_dc == 65535) ? 65535 : m_dc + 1);
            end else if (clr) begin
                m_ovf = 1'b0;
                m_dc  = 0;
            end
        end
        #1;
        chk("out_valid",  32'(out_valid),  32'(m_ov));
        chk("out_data",   32'(out_data),   32'(m_od));
        chk("level",      32'(level),      mq.size() + 32'(m_ov));
        chk("line_avail", 32'(line_avail), 32'(model_has_nl()));
        chk("overflow",   32'(overflow),   32'(m_ovf));
        chk("drop_cnt",   32'(drop_cnt),   32'(m_dc));
    endtask

    initial begin
        logic [7:0] b;

        // Reset state
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 1);
        chk("rst_level", 32'(level), 0);
        chk("rst_valid", 32'(out_valid), 0);

        // Single byte latency
        step(1, 8'h41, 1, 0, 0);
        chk("lat_c1_level", 32'(level), 1);
        chk("lat_c1_valid", 32'(out_valid), 0);
        step(0, 8'h00, 1, 0, 0);
        chk("lat_c2_valid", 32'(out_valid), 1);
        chk("lat_c2_data", 32'(out_data), 32'h41);
        chk("lat_c2_level", 32'(level), 1);
        step(0, 8'h00, 1, 0, 0);
        chk("lat_after_level", 32'(level), 0);

        // Fill to capacity, then overflow
        for (int i = 0; i < 257; i++) begin
            b = 8'(i);
            step(1, b, 0, 0, 0);
        end
        chk("full_level", 32'(level), 257);
        chk("full_ovf", 32'(overflow), 0);
        step(1, 8'hEE, 0, 0, 0);
        chk("drop_ovf", 32'(overflow), 1);
        chk("drop_cnt1", 32'(drop_cnt), 1);
        chk("drop_level", 32'(level), 257);

        // Saturation, then clear coinciding with a drop
        repeat (70000) step(1, 8'($urandom), 0, 0, 0);
        chk("sat_cnt", 32'(drop_cnt), 32'hFFFF);
        step(1, 8'h12, 0, 1, 0);
        chk("clr_drop_cnt", 32'(drop_cnt), 1);
        chk("clr_drop_ovf", 32'(overflow), 1);
        step(0, 8'h00, 0, 1, 0);
        chk("clr_cnt", 32'(drop_cnt), 0);

        // Drain; first 257 bytes come out in order 0..255, 0
        repeat (260) step(0, 8'h00, 1, 0, 0);
        chk("drain_level", 32'(level), 0);

        // Streaming 300 bytes with pointer wrap
        for (int i = 0; i < 300; i++) step(1, 8'($urandom), 1, 0, 0);
        repeat (3) step(0, 8'h00, 1, 0, 0);
        chk("stream_ovf", 32'(overflow), 0);

        // Line detection
        step(1, 8'h61, 0, 0, 0);
        step(1, 8'h62, 0, 0, 0);
        step(1, 8'h0A, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        chk("line_avail_set", 32'(line_avail), 1);
        repeat (3) step(0, 8'h00, 1, 0, 0);
        chk("line_avail_clr", 32'(line_avail), 0);
        step(1, 8'h0A, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        step(1, 8'h0A, 1, 0, 0);
        chk("line_same_cycle", 32'(line_avail), 1);
        repeat (3) step(0, 8'h00, 1, 0, 0);
        chk("line_final", 32'(line_avail), 0);

        // Reset during operation discards held bytes and ignores recv_valid
        for (int i = 0; i < 10; i++) step(1, 8'(i + 16), 0, 0, 0);
        chk("pre_rst_level", 32'(level), 10);
        step(1, 8'h77, 0, 0, 1);
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_level", 32'(level), 0);
        step(1, 8'h55, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        chk("post_rst_data", 32'(out_data), 32'h55);
        chk("post_rst_valid", 32'(out_valid), 1);
        step(0, 8'h00, 1, 0, 0);

        // Random traffic, alternating consumer pressure
        for (int i = 0; i < 3000; i++) begin
            b = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom);
            step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, b,
                 (i % 1000 < 500) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/usb_serial_rx_buffer.md
USB_SERIAL_RX_BUFFER -- requirements
Module: usb_serial_rx_buffer

Interface
REQ-001 SHALL have parameter ASIZE, default 8, meaning the storage depth is 2^ASIZE bytes.
REQ-002 SHALL have port clk, input, 1, meaning the single clock (the USB core clock, 60 MHz); all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, meaning a synchronous, active-high reset.
REQ-004 SHALL have port recv_data, input, 8, meaning the host-to-device byte from the USB-serial top.
REQ-005 SHALL have port recv_valid, input, 1, meaning a one-cycle strobe per received byte; there is no backpressure.
REQ-006 SHALL have port out_data, output, 8, meaning the byte presented to the consumer.
REQ-007 SHALL have port out_valid, output, 1, meaning out_data holds a valid byte.
REQ-008 SHALL have port out_ready, input, 1, meaning the consumer accepts the byte; transfer occurs when out_valid=1 and out_ready=1.
REQ-009 SHALL have port level, output, ASIZE+1, meaning bytes held: memory plus the output stage.
REQ-010 SHALL have port line_avail, output, 1, meaning at least one 0x0A byte is held.
REQ-011 SHALL have port overflow, output, 1, meaning a sticky flag that a byte was dropped.
REQ-012 SHALL have port drop_cnt, output, 16, meaning a saturating count of dropped bytes.
REQ-013 SHALL have port clr_overflow, input, 1, meaning a one-cycle clear of overflow and drop_cnt.

Function
REQ-014 SHALL implement the storage as a 2^ASIZE x 8 memory with synchronous read, inferable as block RAM, and ASIZE+1-bit write and read pointers wptr and rptr.
REQ-015 SHALL flag the memory empty when wptr==rptr, and full when wptr=={~rptr[ASIZE], rptr[ASIZE-1:0]}; pointers wrap modulo 2^(ASIZE+1).
REQ-016 SHALL write recv_data at wptr and increment wptr when recv_valid=1 and the memory is not full.
REQ-017 SHALL drop the byte when recv_valid=1 and the memory is full: no pointer change, overflow<=1, drop_cnt increments and saturates at 0xFFFF.
REQ-018 SHALL load the output stage (out_data<=mem[rptr], out_valid<=1, rptr+1) when the memory is not empty and either out_valid=0 or out_valid&out_ready=1.
REQ-019 SHALL clear out_valid when the output stage is consumed and the memory is empty.
REQ-020 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-021 SHALL give a latency of 2 cycles: a byte strobed in cycle c into an empty block gives out_valid=1 in cycle c+2; a write and a read in the same cycle are both legal.
REQ-022 SHALL sustain back-to-back transfers at one byte per cycle when out_ready is held at 1 and data is available.
REQ-023 SHALL make level equal to the memory count plus out_valid (range 0..2^ASIZE+1), updated on the same edge as the events that change it.
REQ-024 SHALL maintain an ASIZE+1-bit line_cnt that increments on an accepted 0x0A write and decrements on a consumed 0x0A, stays unchanged when both occur in the same cycle, and drives line_avail=(line_cnt!=0); a dropped 0x0A is not counted.
REQ-025 SHALL clear overflow and drop_cnt to 0 on clr_overflow=1, except that a drop in the same cycle wins and gives overflow=1, drop_cnt=1.
REQ-026 SHALL leave memory contents undefined; only pointers and flags define state.

Reset
REQ-027 SHALL set, while rst=1 at a clock edge: wptr=0, rptr=0, out_valid=0, out_data=0x00, level=0, line_cnt=0, line_avail=0, overflow=0, drop_cnt=0.
REQ-028 SHALL discard all held bytes on a reset during operation, and ignore recv_valid during a reset cycle.
REQ-029 SHALL accept a recv_valid strobe in the first cycle after rst falls.

Verification
REQ-030 SHALL cover: reset, then strobe 0x41 in cycle c with out_ready=1 -> out_valid=1 and out_data=0x41 in cycle c+2, level=1 during c+1 and c+2, level=0 after the handshake.
REQ-031 SHALL cover: with ASIZE=8 and out_ready=0, strobe 0..0x100 (257 bytes) -> level=257, overflow=0; then strobe 0xEE -> overflow=1, drop_cnt=1, level stays 257.
REQ-032 SHALL cover: with out_ready=1, stream 300 bytes at one per cycle -> output sequence identical to input, no gaps after the first byte, pointer wrap passed, overflow=0.
REQ-033 SHALL cover: strobe "ab\n" with out_ready=0 -> line_avail=1; consume 3 bytes -> line_avail=0; a 0x0A written while another 0x0A is consumed in the same cycle -> line_cnt unchanged.
REQ-034 SHALL cover: at saturation, 70000 dropped bytes -> drop_cnt=0xFFFF; clr_overflow coinciding with a drop -> drop_cnt=1, overflow=1.
REQ-035 SHALL cover: with 10 bytes held, assert rst for one cycle -> the next cycle shows out_valid=0 and level=0, and a new byte 0x55 emerges first.
